// File: rtl/adder_result_checker.sv
// Golden-model checker for a WIDTH-bit adder: accepts (a, b, sum) over valid/ready and compares one cycle after accept.
// in_ready drops once NUM_VECTORS vectors are taken; a held in_valid is never consumed in that case.
module adder_result_checker #(
  parameter int WIDTH       = 3,
  parameter int NUM_VECTORS = 21,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH:0]   fail_sum
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic               s1_vld;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [WIDTH:0]     s1_sum;
  logic [WIDTH:0]     expected;
  logic               accept;
  logic               mismatch;
  logic [CNT_W-1:0]   err_next;

  assign in_ready = (state == RUN) && (vec_count < CNT_W'(NUM_VECTORS));
  assign accept   = in_valid && in_ready;

  // Zero-extending both operands keeps the carry-out, so the golden sum cannot overflow.
  assign expected = {1'b0, s1_a} + {1'b0, s1_b};
  assign mismatch = s1_vld && (expected != s1_sum);

  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != {CNT_W{1'b1}})) begin
      err_next = err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s1_vld     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_sum     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      vec_count  <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_sum   <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_sum <= in_sum;
      end

      err_count <= err_next;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_a     <= s1_a;
        fail_b     <= s1_b;
        fail_sum   <= s1_sum;
      end

      case (state)
        IDLE, DONE: begin
          // The compare stage is always empty here, so the run-start clears win cleanly.
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_sum   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            vec_count <= vec_count + CNT_W'(1);
            if (vec_count == CNT_W'(NUM_VECTORS - 1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == '0);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
Sequential self-checking consumer that sits directly downstream of carry_ripple_adder. It accepts operand/result vectors (a, b, out) over a valid/ready handshake and compares each result against a golden a+b. It counts vectors and mismatches and captures the first failing vector. Designed for hardware-in-loop regression of the adder, replacing $monitor-based eyeball checking.

Parameters:
WIDTH, 3, operand width; sum width is WIDTH+1
NUM_VECTORS, 21, vectors per run (20 random plus final 7+7 corner)
CNT_W, 8, width of vector and error counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a run from IDLE or DONE
in_valid  input  1  upstream vector valid
in_ready  output  1  checker can accept a vector
in_a  input  WIDTH  operand a fed to the adder
in_b  input  WIDTH  operand b fed to the adder
in_sum  input  WIDTH+1  adder output for (in_a, in_b)
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE
pass  output  1  valid when done; 1 iff err_count == 0
vec_count  output  CNT_W  vectors accepted this run
err_count  output  CNT_W  mismatches this run, saturating
fail_valid  output  1  a first failure has been captured
fail_a  output  WIDTH  a of first failing vector
fail_b  output  WIDTH  b of first failing vector
fail_sum  output  WIDTH+1  observed sum of first failing vector

Behaviour:
- Reset: one clock and reset only; rst is synchronous and active-high. On rst, state=IDLE and every output = 0: in_ready, busy, done, pass, vec_count, err_count, fail_valid, fail_a, fail_b and fail_sum. rst overrides every other input in the same cycle, including a mid-run reset; the partial run is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Entry clears vec_count, err_count, fail_* and pass.
  - RUN -> DRAIN on the cycle the NUM_VECTORS-th vector is accepted.
  - DRAIN -> DONE after 1 cycle, once the compare pipeline is empty.
  - DONE -> RUN on start, with the same clears as IDLE -> RUN. Otherwise DONE holds.
  - start in RUN or DRAIN is ignored.
- Handshake: in_ready = (state==RUN) and (vec_count < NUM_VECTORS), driven combinationally from registered state.
  - Accept occurs when in_valid and in_ready are both high.
  - in_valid while in_ready=0 is not consumed; the upstream must hold the vector.
  - Back-to-back accepts every cycle are supported.
- Pipeline:
  - Stage 1 registers in_a, in_b and in_sum on accept, with a stage valid bit.
  - Stage 2 computes expected = zero-extended in_a + zero-extended in_b at WIDTH+1 bits, so there is no overflow, and compares it to the registered sum.
  - vec_count increments on the accept cycle.
  - err_count and fail_* update 1 cycle after accept. Total check latency is 1 cycle.
- Errors:
  - err_count increments on each mismatch and saturates at 2^CNT_W-1.
  - fail_* load only on the first mismatch of a run (fail_valid 0 -> 1) and then hold until the next run start.
- pass is registered on DRAIN -> DONE as (err_count_next == 0). It is stable while done=1.
- done and busy are mutually exclusive. done stays high until start or rst.

Test Plan:
- Reset then idle: assert rst 2 cycles, hold in_valid=1 -> in_ready=0, all outputs 0, vec_count stays 0.
- Clean run: start, then 20 correct vectors (sum = a+b) plus a=7, b=7, sum=14, all back-to-back -> vec_count=21, err_count=0; done rises 2 cycles after the last accept; pass=1, fail_valid=0.
- Injected faults: run with vector 5 = (3, 4, sum=6) and vector 9 = (7, 7, sum=15) -> err_count=2, fail_a=3, fail_b=4, fail_sum=6, pass=0.
- Backpressure and boundary: hold in_valid=1 after the 21st accept -> in_ready=0, no 22nd accept, vec_count=21. start pulsed mid-run -> ignored.
- Mid-run reset: after 10 vectors with 1 error, assert rst -> all outputs 0 next cycle, state IDLE; a new start gives a fresh run with counts starting at 0.
- Restart from DONE: start while done=1 -> done=0, busy=1, counters and fail_* cleared the same cycle; a second clean run ends with pass=1.
